// File: rtl/seg_scan_pkg.sv
// Shared types, anode patterns and the hex-to-segment decode for the display scanner.
package seg_scan_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SCAN  = 1'b1
    } state_e;

    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [3:0] ANODE_D0  = 4'b1110;
    localparam logic [3:0] ANODE_D1  = 4'b1101;
    localparam logic [3:0] ANODE_D2  = 4'b1011;
    localparam logic [3:0] ANODE_D3  = 4'b0111;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    function automatic logic [3:0] digit_anode(input logic [1:0] sel);
        case (sel)
            2'd0:    return ANODE_D0;
            2'd1:    return ANODE_D1;
            2'd2:    return ANODE_D2;
            default: return ANODE_D3;
        endcase
    endfunction

    // Active-low, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_tick.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1, tick high on the terminal count,
// synchronous clear restarts a digit slot.
module seg_ref_tick #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic clkin,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int unsigned   CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with double-buffered value.
// Define SEG_SCAN_BLANK_EN to blank leading-zero digits.
//
// state    | meaning
// ST_BLANK | display dark, waiting for the first value after reset
// ST_SCAN  | cycling digits, new values committed only at frame wrap
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        load,
    output logic        load_ready,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic [1:0]  digit_sel,
    output logic        frame_done
);
    state_e      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] pend_q, pend_d;
    logic [15:0] act_q, act_d;
    logic        pvld_q, pvld_d;
    logic [3:0]  anode_q, anode_d;
    logic [6:0]  seg_q, seg_d;
    logic        tick, commit_blank, wrap, blank_dig;
    logic [3:0]  nibble;

    seg_ref_tick #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
        .clkin (clkin),
        .reset (reset),
        .clr   (commit_blank),
        .tick  (tick)
    );

`ifdef SEG_SCAN_BLANK_EN
    logic [3:0] lead_zero;
    assign lead_zero[3] = (act_q[15:12] == 4'h0);
    assign lead_zero[2] = lead_zero[3] && (act_q[11:8] == 4'h0);
    assign lead_zero[1] = lead_zero[2] && (act_q[7:4] == 4'h0);
    assign lead_zero[0] = 1'b0;
    assign blank_dig    = lead_zero[sel_q];
`else
    assign blank_dig    = 1'b0;
`endif

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q <= ST_BLANK;
            sel_q   <= 2'd0;
            pend_q  <= 16'h0000;
            act_q   <= 16'h0000;
            pvld_q  <= 1'b0;
            anode_q <= ANODE_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            pvld_q  <= pvld_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (pvld_q) state_d = ST_SCAN;
            ST_SCAN:  state_d = ST_SCAN;
            default:  state_d = ST_BLANK;
        endcase
    end

    always_comb begin
        commit_blank = (state_q == ST_BLANK) && pvld_q;
        wrap         = (state_q == ST_SCAN) && tick && (sel_q == 2'd3);
        load_ready   = ~pvld_q;
        frame_done   = wrap;

        sel_d  = sel_q;
        act_d  = act_q;
        pend_d = pend_q;
        pvld_d = pvld_q;
        if (commit_blank) begin
            act_d  = pend_q;
            pvld_d = 1'b0;
            sel_d  = 2'd0;
        end else if ((state_q == ST_SCAN) && tick) begin
            sel_d = sel_q + 2'd1;
            if (wrap && pvld_q) begin
                act_d  = pend_q;
                pvld_d = 1'b0;
            end
        end
        // A commit needs a full buffer, so it can never collide with a capture
        if (load && !pvld_q) begin
            pend_d = data_in;
            pvld_d = 1'b1;
        end

        nibble  = act_q[{sel_q, 2'b00} +: 4];
        anode_d = ANODE_OFF;
        seg_d   = SEG_OFF;
        if (state_q == ST_SCAN) begin
            anode_d = blank_dig ? ANODE_OFF : digit_anode(sel_q);
            seg_d   = hex_to_seg(nibble);
        end
    end

    assign anode     = anode_q;
    assign seg       = seg_q;
    assign digit_sel = sel_q;
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clkin cycles per digit slot (minimum 2).
REQ-002 SHALL have port clkin  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port data_in  input  16  value to display, four hex digits; [3:0] is digit 0.
REQ-005 SHALL have port load  input  1  request to capture data_in.
REQ-006 SHALL have port load_ready  output  1  high when a load is accepted this cycle.
REQ-007 SHALL have port anode  output  4  active-low digit enables.
REQ-008 SHALL have port seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-009 SHALL have port digit_sel  output  2  index of the digit currently driven.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at frame wrap.

Function
REQ-011 SHALL keep a prescaler counting 0..REFRESH_DIV-1 and wrapping to 0; tick is asserted when the count equals REFRESH_DIV-1.
REQ-012 SHALL implement FSM states BLANK and SCAN; BLANK follows reset.
REQ-013 SHALL hold a pending register with a valid flag; load_ready equals NOT pending_valid.
REQ-014 SHALL capture data_in into pending and set pending_valid on any cycle with load=1 and load_ready=1; load with load_ready=0 is ignored, with no error.
REQ-015 In BLANK with pending_valid=1, SHALL copy pending to the active register, clear pending_valid, set digit_sel=0, clear the prescaler and enter SCAN on the next edge.
REQ-016 In SCAN, SHALL advance digit_sel by 1 modulo 4 on each tick.
REQ-017 On a tick with digit_sel=3, SHALL pulse frame_done for that cycle; if pending_valid=1, it SHALL also commit pending to active and clear pending_valid on the same edge.
REQ-018 When a load and a commit coincide (pending empty, so load_ready=1), SHALL capture the new value into pending; it is committed at the next frame wrap.
REQ-019 SHALL register anode and seg, valid one cycle after digit_sel changes (latency 1).
REQ-020 SHALL map digit_sel 0/1/2/3 to anode 4'b1110/1101/1011/0111 respectively.
REQ-021 SHALL decode the active nibble for the selected digit to hex 0-F using the standard active-low 7-segment table.
REQ-022 In BLANK, SHALL drive anode=4'b1111 and seg=7'h7F.
REQ-023 SHALL never change the active register except at the commit points in REQ-015 and REQ-017, so no frame shows mixed values.

Reset
REQ-024 On reset, SHALL immediately set the state to BLANK, prescaler=0, digit_sel=0, pending_valid=0, active=16'h0000, anode=4'b1111, seg=7'h7F, frame_done=0 and load_ready=1.
REQ-025 Reset asserted mid-frame SHALL discard both pending and active values; display resumes only after a new load.

Configuration
REQ-026 With macro SEG_SCAN_BLANK_EN defined, SHALL force anode=4'b1111 for leading-zero digits (digits above the most-significant nonzero digit); digit 0 is always shown, and digit_sel and frame timing are unchanged.
REQ-027 Without SEG_SCAN_BLANK_EN, SHALL drive all four digits in every frame.

Structure
REQ-028 Package seg_scan_pkg SHALL hold the state enum, the anode one-hot-low constants and the hex-to-7-segment function.
REQ-029 The prescaler SHALL be sub-module seg_ref_tick (ports clkin, reset; output tick), instantiated once.

Verification (REFRESH_DIV=4)
REQ-030 Reset: assert reset -> anode=1111, seg=7F, load_ready=1, digit_sel=0, frame_done=0.
REQ-031 Load 16'h1A2F from BLANK -> SCAN on the next edge; then seg sequence F:0E, 2:24, A:08, 1:79 with anode 1110, 1101, 1011, 0111, 4 cycles each; frame_done pulses every 16 cycles.
REQ-032 Load 16'h1234 mid-frame -> load_ready=0 until the frame_done edge; the display keeps the old value until the wrap, then shows 1234. A second load while load_ready=0 is ignored.
REQ-033 Load on the frame_done cycle with pending empty -> value is captured and displayed only after the following wrap.
REQ-034 With SEG_SCAN_BLANK_EN and 16'h0005 loaded -> anode=1110 with seg=12 in slot 0, and anode=1111 in slots 1-3; without the macro, digits 1-3 show seg=40.
REQ-035 Assert reset during slot 2 -> outputs return to the REQ-024 values asynchronously; no display until a new load.
